pipe_skid_reg: RTL and testbench

Parametrised, elastic pipeline register that replaces the fixed inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) of the pipelined datapath.
- Carries a data bundle plus a control bundle between stages.
- Upstream and downstream use a valid/ready handshake, backed by a 2-entry skid buffer, so stalls do not lose data.
- Synchronous flush turns the stage into a bubble, with the control bits forced to zero.
- A saturating stall counter is provided for performance visibility.

---
 rtl/pipe_pkg.sv | 13 +
 rtl/sat_counter.sv | 23 ++
 rtl/pipe_skid_reg.sv | 101 ++++++++++
 tb/tb_pipe_skid_reg.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared encodings and per-stage bundle widths for the elastic pipeline registers.
package pipe_pkg;
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b10;

  // IF/ID: pc + instr; ID/EX: pc + rd1 + rd2 + imm + rt + rd; MEM/WB: rdata + alu + regDst
  localparam int IFID_W       = 64;
  localparam int IDEX_W       = 138;
  localparam int EXMEM_DATA_W = 102;
  localparam int EXMEM_CTRL_W = 5;
  localparam int MEMWB_W      = 69;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter, updated on the falling clock edge, async active-high reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign count = cnt_q;
endmodule

// File: rtl/pipe_skid_reg.sv
// Elastic inter-stage register: valid/ready handshake over a 2-entry skid buffer,
// synchronous flush to a bubble, and a saturating stall counter.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W     = EXMEM_DATA_W,
  parameter int CTRL_W     = EXMEM_CTRL_W,
  parameter int CNT_W      = 16,
  parameter bit CLEAR_CTRL = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_count
);
  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic              in_xfer, out_xfer;

  // in_ready depends on registered state only, never on out_ready
  assign in_ready  = (state_q != ST_FULL) & ~reset;
  assign out_valid = (state_q != ST_EMPTY);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush) begin
      state_d     = ST_EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end else begin
      case (state_q)
        ST_EMPTY: if (in_xfer) begin
          state_d     = ST_BUSY;
          main_data_d = in_data;
          main_ctrl_d = in_ctrl;
        end
        ST_BUSY: begin
          if (in_xfer && out_xfer) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (in_xfer) begin
            state_d     = ST_FULL;
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: if (out_xfer) begin
          state_d     = ST_BUSY;
          main_data_d = skid_data_q;
          main_ctrl_d = skid_ctrl_q;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

  assign out_data  = main_data_q;
  assign out_ctrl  = (CLEAR_CTRL && !out_valid) ? '0 : main_ctrl_q;
  assign occupancy = (state_q == ST_FULL) ? 2'd2 : (state_q == ST_BUSY) ? 2'd1 : 2'd0;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (out_valid & ~out_ready),
    .count (stall_count)
  );
endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboarded bench for pipe_skid_reg: handshake ordering, stalls, flush, async reset, saturation.
module tb_pipe_skid_reg;
  localparam int DW = 102;
  localparam int CW = 5;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [CW-1:0] ctrl;
  } beat_t;

  logic          clk = 1'b0, reset = 1'b1, flush = 1'b0;
  logic          in_valid = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic          in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [1:0]    occupancy;
  logic [15:0]   stall_count;

  logic          in_valid3 = 1'b0, out_ready3 = 1'b0, flush3 = 1'b0;
  logic [DW-1:0] in_data3 = '0;
  logic [CW-1:0] in_ctrl3 = '0;
  logic          in_ready3, out_valid3;
  logic [DW-1:0] out_data3;
  logic [CW-1:0] out_ctrl3;
  logic [1:0]    occupancy3;
  logic [2:0]    stall_count3;

  int n_chk = 0;
  int n_err = 0;
  beat_t sb[$];

  always #5 clk = ~clk;

  pipe_skid_reg dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy), .stall_count(stall_count)
  );

  pipe_skid_reg #(.CNT_W(3)) dut3 (
    .clk(clk), .reset(reset), .flush(flush3),
    .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3), .in_ctrl(in_ctrl3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3), .out_ctrl(out_ctrl3),
    .occupancy(occupancy3), .stall_count(stall_count3)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // drive/check point: just after the active (falling) edge
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c);
    in_valid = v;
    in_data  = d;
    in_ctrl  = c;
  endtask

  // posedge sits between drive points and the falling edge that consumes them
  always @(posedge clk) begin
    beat_t e;
    if (!reset) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          e = sb.pop_front();
          chk("sb_data", out_data, e.data);
          chk("sb_ctrl", out_ctrl, e.ctrl);
        end
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back('{data: in_data, ctrl: in_ctrl});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    tick(); tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_data", out_data, 0);
    chk("rst_ctrl", out_ctrl, 0);
    chk("rst_stall", stall_count, 0);
    reset = 1'b0;
    #1 chk("post_rst_ready", in_ready, 1);

    // single beat
    out_ready = 1'b1;
    drive(1'b1, 102'h1234, 5'b10110);
    tick();
    chk("s1_valid", out_valid, 1);
    chk("s1_data", out_data, 102'h1234);
    chk("s1_ctrl", out_ctrl, 5'b10110);
    chk("s1_occ", occupancy, 1);
    drive(1'b0, '0, '0);
    tick();
    chk("s1_empty", out_valid, 0);
    chk("s1_ctrl_clr", out_ctrl, 0);
    chk("s1_data_keep", out_data, 102'h1234);

    // stream 1..8 at full rate
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, DW'(i), CW'(i));
      tick();
      chk("st_ready", in_ready, 1);
      chk("st_valid", out_valid, 1);
      chk("st_head", out_data, DW'(i));
    end
    drive(1'b0, '0, '0);
    tick(); tick();
    chk("st_stall", stall_count, 0);

    // backpressure: A to main, B to skid, C held upstream
    out_ready = 1'b0;
    drive(1'b1, 102'hA, 5'h0A);
    tick();
    drive(1'b1, 102'hB, 5'h0B);
    tick();
    drive(1'b1, 102'hC, 5'h0C);
    tick();
    chk("bp_occ", occupancy, 2);
    chk("bp_ready", in_ready, 0);
    chk("bp_head", out_data, 102'hA);
    chk("bp_stall2", stall_count, 2);
    tick(); tick();
    out_ready = 1'b1;
    tick();
    chk("bp_head_b", out_data, 102'hB);
    tick();
    chk("bp_head_c", out_data, 102'hC);
    drive(1'b0, '0, '0);
    tick(); tick();
    chk("bp_empty", out_valid, 0);
    chk("bp_stall4", stall_count, 4);

    // flush while FULL, then flush swallowing an accepted beat
    out_ready = 1'b0;
    drive(1'b1, 102'hD, 5'h0D);
    tick();
    drive(1'b1, 102'hE, 5'h0E);
    tick();
    chk("fl_full", occupancy, 2);
    flush = 1'b1;
    drive(1'b1, 102'hF, 5'h0F);
    tick();
    chk("fl_valid", out_valid, 0);
    chk("fl_occ", occupancy, 0);
    chk("fl_ctrl", out_ctrl, 0);
    chk("fl_ready", in_ready, 1);
    drive(1'b1, 102'h6, 5'h06);
    tick();
    chk("fl_drop", out_valid, 0);
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 102'h7, 5'h07);
    tick();
    chk("fl_next", out_data, 102'h7);
    drive(1'b0, '0, '0);
    tick();
    chk("fl_stall6", stall_count, 6);

    // async reset mid-cycle while FULL
    out_ready = 1'b0;
    drive(1'b1, 102'h11, 5'h11);
    tick();
    drive(1'b1, 102'h22, 5'h12);
    tick();
    drive(1'b0, '0, '0);
    chk("ar_full", occupancy, 2);
    #2 reset = 1'b1;
    sb.delete();
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_occ", occupancy, 0);
    chk("ar_data", out_data, 0);
    chk("ar_ctrl", out_ctrl, 0);
    chk("ar_stall", stall_count, 0);
    chk("ar_ready", in_ready, 0);
    tick();
    reset = 1'b0;
    #1 chk("ar_ready_back", in_ready, 1);
    out_ready = 1'b1;
    drive(1'b1, 102'h33, 5'h13);
    tick();
    chk("ar_new_valid", out_valid, 1);
    chk("ar_new_data", out_data, 102'h33);
    drive(1'b0, '0, '0);
    tick();

    // 3-bit stall counter saturation
    in_valid3 = 1'b1;
    in_data3  = 102'h77;
    in_ctrl3  = 5'h07;
    tick();
    in_valid3 = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("sat_cnt", stall_count3, (k > 7) ? 7 : k);
    end

    chk("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
